stage_mem2: RTL and testbench
=============================

STAGE_MEM2 -- requirements
Module: stage_mem2

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock.
REQ-002 SHALL have port rstn_i, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port lsu_rdata_i, input, 32, LSU read word; valid exactly one cycle after the MEM1 request cycle.
REQ-004 SHALL have MEM1/MEM2 inputs: instr_valid_i 1, is_csr_i 1, csr_we_i 1, csr_waddr_i 12, csr_wdata_i 32, write_rd_i 1, rd_addr_i 5, alu_result_i 32, mem_oper_i mem_oper_t, trap_i exc_t.
REQ-005 SHALL have control inputs stall_i 1 (hold MEM2/WB registers) and flush_i 1 (kill MEM2/WB contents).
REQ-006 SHALL have MEM2/WB outputs: instr_valid_o 1, is_csr_o 1, csr_we_o 1, csr_waddr_o 12, csr_wdata_o 32, write_rd_o 1, rd_addr_o 5, wb_data_o 32, trap_o exc_t.
REQ-007 SHALL have forwarding outputs fwd_valid_o 1, fwd_rd_o 5, fwd_data_o 32 (combinational, current MEM2 result).

Function
REQ-008 Load alignment: byte lane = alu_result_i[1:0]; LB/LBU select byte lane, LH/LHU select half alu_result_i[1], LW full word.
REQ-009 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend.
REQ-010 Result SHALL be the formatted load data for load opers, else alu_result_i.
REQ-011 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL raise LOAD_ADDR_MISALIGNED / STORE_ADDR_MISALIGNED, only if trap_i == NO_TRAP; an incoming trap_i has priority and passes unchanged.
REQ-012 Any trap (incoming or raised) SHALL force registered write_rd_o=0 and csr_we_o=0, and fwd_valid_o=0.
REQ-013 Load-data hold: on the first stall_i cycle with a load in MEM2, lsu_rdata_i SHALL be captured into a hold register and marked valid.
REQ-014 While hold valid, formatting SHALL use the held word, not lsu_rdata_i.
REQ-015 Hold valid SHALL clear on the first cycle stall_i=0 (the register update cycle uses held data) or on flush_i.
REQ-016 Stall and flush simultaneous: flush_i SHALL win.
REQ-017 Registers: if flush_i, control outputs take reset values; else if !stall_i, all outputs load from inputs/result; else hold.
REQ-018 fwd_valid_o = instr_valid_i & write_rd_i & no trap & rd_addr_i != 0; fwd_rd_o = rd_addr_i; fwd_data_o = REQ-010 result.
REQ-019 Latency: MEM2 inputs to WB outputs exactly one cycle when unstalled.

Reset
REQ-020 On rstn_i=0 at clk edge: instr_valid_o=0, write_rd_o=0, is_csr_o=0, csr_we_o=0, trap_o=NO_TRAP, hold valid=0.
REQ-021 Data outputs (rd_addr_o, wb_data_o, csr_waddr_o, csr_wdata_o) need not reset.
REQ-022 Reset asserted mid-stall SHALL discard held load data.

Structure
REQ-023 mem_oper_t (MEM_NOP, LB, LBU, LH, LHU, LW, SB, SH, SW) and exc_t (incl. LOAD_ADDR_MISALIGNED, STORE_ADDR_MISALIGNED) SHALL live in riscv_pkg.
REQ-024 Load formatting SHALL be one combinational sub-module, load_formatter (inputs oper, addr[1:0], word; output 32-bit data).
REQ-025 Hold register and pipeline registers SHALL remain in stage_mem2.

Verification
REQ-026 LB, addr 0x...3, rdata 0x80FF_FF12 -> wb_data_o=0xFFFF_FF80 next cycle; LBU -> 0x0000_0080.
REQ-027 LH addr 0x...2, rdata 0x8001_1234 -> 0xFFFF_8001; LH addr 0x...1 -> trap_o=LOAD_ADDR_MISALIGNED, write_rd_o=0.
REQ-028 LW rdata 0xDEAD_BEEF, stall_i high 3 cycles, lsu_rdata_i changed to 0 after cycle 1 -> wb_data_o=0xDEAD_BEEF after release.
REQ-029 stall_i and flush_i both high with valid ALU op -> instr_valid_o=0, write_rd_o=0 next cycle, hold valid cleared.
REQ-030 trap_i=ILLEGAL_INSTR with misaligned SW -> trap_o=ILLEGAL_INSTR (not STORE_ADDR_MISALIGNED); rd_addr_i=0 write -> fwd_valid_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types.
//   mem_oper_t : memory operation carried down the pipe with each instruction
//   exc_t      : trap cause carried down the pipe (NO_TRAP when clean)
//   is_load()  : true for the five load operations
package riscv_pkg;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    LB      = 4'd1,
    LBU     = 4'd2,
    LH      = 4'd3,
    LHU     = 4'd4,
    LW      = 4'd5,
    SB      = 4'd6,
    SH      = 4'd7,
    SW      = 4'd8
  } mem_oper_t;

  typedef enum logic [3:0] {
    NO_TRAP               = 4'd0,
    INSTR_ADDR_MISALIGNED = 4'd1,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    STORE_ADDR_MISALIGNED = 4'd5,
    ECALL                 = 4'd6
  } exc_t;

  function automatic logic is_load(input mem_oper_t oper);
    return (oper == LB) || (oper == LBU) || (oper == LH) ||
           (oper == LHU) || (oper == LW);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load data alignment and extension.
//   oper : memory operation (non-load operations pass word through)
//   addr : low two bits of the effective address (byte lane)
//   word : raw 32-bit word returned by the LSU
//   data : aligned, sign- or zero-extended load result
module load_formatter
  import riscv_pkg::*;
(
  input  mem_oper_t   oper,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (addr)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
  end

  // Halfword lane is chosen by addr[1] only; addr[0] set is a misalignment
  // trapped elsewhere, so the data here is don't-care in that case.
  assign half_v = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (oper)
      LB:      data = {{24{byte_v[7]}}, byte_v};
      LBU:     data = {24'd0, byte_v};
      LH:      data = {{16{half_v[15]}}, half_v};
      LHU:     data = {16'd0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/stage_mem2.sv
// MEM2 pipeline stage: formats load data, detects misaligned accesses,
// provides the forwarding path and holds the MEM2/WB pipeline registers.
//   clk_i, rstn_i        : clock, synchronous active-low reset
//   lsu_rdata_i          : LSU read word, valid one cycle after MEM1 request
//   instr_valid_i ..     : MEM1/MEM2 instruction fields
//   stall_i / flush_i    : hold / kill the MEM2/WB registers (flush wins)
//   *_o (WB group)       : registered MEM2/WB outputs
//   fwd_valid_o/rd/data  : combinational forwarding of the current result
//
// Pipeline semantics: there is no valid/ready handshake here; an
// instruction advances into the WB registers on every edge where stall_i
// is low, and flush_i turns the WB slot into a bubble regardless of stall.
module stage_mem2
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        instr_valid_i,
  input  logic        is_csr_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  mem_oper_t   mem_oper_i,
  input  exc_t        trap_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        instr_valid_o,
  output logic        is_csr_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] wb_data_o,
  output exc_t        trap_o,
  output logic        fwd_valid_o,
  output logic [4:0]  fwd_rd_o,
  output logic [31:0] fwd_data_o
);

  logic        hold_valid_q;
  logic [31:0] hold_word_q;
  logic        load_op;
  logic [31:0] fmt_word;
  logic [31:0] load_data;
  logic [31:0] result;
  exc_t        trap_eff;
  logic        trap_any;

  assign load_op = is_load(mem_oper_i);

  // The LSU word is only present for one cycle; once captured during a
  // stall, the held copy feeds the formatter until the stage advances.
  assign fmt_word = hold_valid_q ? hold_word_q : lsu_rdata_i;

  load_formatter u_load_formatter (
    .oper (mem_oper_i),
    .addr (alu_result_i[1:0]),
    .word (fmt_word),
    .data (load_data)
  );

  assign result = load_op ? load_data : alu_result_i;

  // An incoming trap keeps priority; misalignment only raised on clean
  // instructions. Bubbles never raise a trap.
  always_comb begin
    trap_eff = trap_i;
    if (instr_valid_i && (trap_i == NO_TRAP)) begin
      case (mem_oper_i)
        LH, LHU: if (alu_result_i[0])           trap_eff = LOAD_ADDR_MISALIGNED;
        LW:      if (alu_result_i[1:0] != 2'd0) trap_eff = LOAD_ADDR_MISALIGNED;
        SH:      if (alu_result_i[0])           trap_eff = STORE_ADDR_MISALIGNED;
        SW:      if (alu_result_i[1:0] != 2'd0) trap_eff = STORE_ADDR_MISALIGNED;
        default: trap_eff = trap_i;
      endcase
    end
  end

  assign trap_any = (trap_eff != NO_TRAP);

  assign fwd_valid_o = instr_valid_i & write_rd_i & ~trap_any & (rd_addr_i != 5'd0);
  assign fwd_rd_o    = rd_addr_i;
  assign fwd_data_o  = result;

  // Load-data hold register. Reset and flush discard it; the first
  // unstalled edge consumes it (the WB registers load from held data on
  // that same edge) and clears it.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hold_valid_q <= 1'b0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
    end else if (!stall_i) begin
      hold_valid_q <= 1'b0;
    end else if (instr_valid_i && load_op && !hold_valid_q) begin
      hold_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && !flush_i && stall_i && instr_valid_i && load_op && !hold_valid_q) begin
      hold_word_q <= lsu_rdata_i;
    end
  end

  // Control half of the MEM2/WB register: reset and flush give a bubble.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      instr_valid_o <= 1'b0;
      is_csr_o      <= 1'b0;
      csr_we_o      <= 1'b0;
      write_rd_o    <= 1'b0;
      trap_o        <= NO_TRAP;
    end else if (!stall_i) begin
      instr_valid_o <= instr_valid_i;
      is_csr_o      <= is_csr_i;
      csr_we_o      <= csr_we_i & ~trap_any;
      write_rd_o    <= write_rd_i & ~trap_any;
      trap_o        <= trap_eff;
    end
  end

  // Data half: no reset needed, qualified by the control bits above.
  always_ff @(posedge clk_i) begin
    if (!flush_i && !stall_i) begin
      csr_waddr_o <= csr_waddr_i;
      csr_wdata_o <= csr_wdata_i;
      rd_addr_o   <= rd_addr_i;
      wb_data_o   <= result;
    end
  end

endmodule

// File: tb/tb_stage_mem2.sv
module tb_stage_mem2;
  import riscv_pkg::*;

  localparam int W = 42; // {write_rd, trap[3:0], rd[4:0], wb_data[31:0]}

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] lsu_rdata_i;
  logic        instr_valid_i;
  logic        is_csr_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        write_rd_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] alu_result_i;
  mem_oper_t   mem_oper_i;
  exc_t        trap_i;
  logic        stall_i;
  logic        flush_i;
  logic        instr_valid_o;
  logic        is_csr_o;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        write_rd_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wb_data_o;
  exc_t        trap_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic mon_upd;

  stage_mem2 dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .lsu_rdata_i   (lsu_rdata_i),
    .instr_valid_i (instr_valid_i),
    .is_csr_i      (is_csr_i),
    .csr_we_i      (csr_we_i),
    .csr_waddr_i   (csr_waddr_i),
    .csr_wdata_i   (csr_wdata_i),
    .write_rd_i    (write_rd_i),
    .rd_addr_i     (rd_addr_i),
    .alu_result_i  (alu_result_i),
    .mem_oper_i    (mem_oper_i),
    .trap_i        (trap_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .is_csr_o      (is_csr_o),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .write_rd_o    (write_rd_o),
    .rd_addr_o     (rd_addr_o),
    .wb_data_o     (wb_data_o),
    .trap_o        (trap_o),
    .fwd_valid_o   (fwd_valid_o),
    .fwd_rd_o      (fwd_rd_o),
    .fwd_data_o    (fwd_data_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every edge that advances the stage with a valid instruction
  // presents one WB result, which must match the head of the queue.
  always @(posedge clk_i) begin
    mon_upd = rstn_i && !stall_i && !flush_i;
    #1;
    if (mon_upd && instr_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_wb: got %0h expected none", wb_data_o);
      end else begin
        check("wb_result", {22'd0, write_rd_o, trap_o, rd_addr_o, wb_data_o}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    instr_valid_i = 1'b0;
    is_csr_i      = 1'b0;
    csr_we_i      = 1'b0;
    csr_waddr_i   = 12'd0;
    csr_wdata_i   = 32'd0;
    write_rd_i    = 1'b0;
    rd_addr_i     = 5'd0;
    alu_result_i  = 32'd0;
    mem_oper_i    = MEM_NOP;
    trap_i        = NO_TRAP;
    lsu_rdata_i   = 32'd0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic op(input mem_oper_t o, input logic [31:0] alu, input logic [31:0] rdata,
                    input logic [4:0] rd, input logic wr, input exc_t tr);
    idle();
    instr_valid_i = 1'b1;
    mem_oper_i    = o;
    alu_result_i  = alu;
    lsu_rdata_i   = rdata;
    rd_addr_i     = rd;
    write_rd_i    = wr;
    trap_i        = tr;
  endtask

  task automatic push(input logic wr, input exc_t tr, input logic [4:0] rd, input logic [31:0] wb);
    exp_q.push_back({wr, tr, rd, wb});
  endtask

  task automatic after_edge();
    @(posedge clk_i);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_instr_valid", instr_valid_o, 0);
    check("rst_write_rd", write_rd_o, 0);
    check("rst_is_csr", is_csr_o, 0);
    check("rst_csr_we", csr_we_o, 0);
    check("rst_trap", trap_o, NO_TRAP);
    check("rst_hold_valid", dut.hold_valid_q, 0);
    rstn_i = 1'b1;

    // Plain ALU result and its forwarding
    op(MEM_NOP, 32'h1234_5678, 32'h0, 5'd5, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd5, 32'h1234_5678);
    #1;
    check("fwd_valid_alu", fwd_valid_o, 1);
    check("fwd_rd_alu", fwd_rd_o, 5);
    check("fwd_data_alu", fwd_data_o, 32'h1234_5678);
    @(negedge clk_i);

    // Byte / half formatting
    op(LB, 32'h0000_1003, 32'h80FF_FF12, 5'd1, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd1, 32'hFFFF_FF80);
    #1;
    check("fwd_data_lb", fwd_data_o, 32'hFFFF_FF80);
    @(negedge clk_i);
    op(LBU, 32'h0000_1003, 32'h80FF_FF12, 5'd1, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd1, 32'h0000_0080);
    @(negedge clk_i);
    op(LH, 32'h0000_1002, 32'h8001_1234, 5'd2, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd2, 32'hFFFF_8001);
    @(negedge clk_i);
    op(LHU, 32'h0000_1000, 32'h8001_1234, 5'd2, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd2, 32'h0000_1234);
    @(negedge clk_i);
    op(LB, 32'h0000_1001, 32'h0000_7F00, 5'd6, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd6, 32'h0000_007F);
    @(negedge clk_i);

    // Misaligned accesses and trap priority
    op(LH, 32'h0000_1001, 32'h8001_1234, 5'd3, 1'b1, NO_TRAP);
    push(1'b0, LOAD_ADDR_MISALIGNED, 5'd3, 32'h0000_1234);
    #1;
    check("fwd_valid_mis", fwd_valid_o, 0);
    @(negedge clk_i);
    op(SW, 32'h0000_3001, 32'h0, 5'd0, 1'b0, NO_TRAP);
    push(1'b0, STORE_ADDR_MISALIGNED, 5'd0, 32'h0000_3001);
    @(negedge clk_i);
    op(SW, 32'h0000_3002, 32'h0, 5'd0, 1'b0, ILLEGAL_INSTR);
    push(1'b0, ILLEGAL_INSTR, 5'd0, 32'h0000_3002);
    @(negedge clk_i);

    // Write to x0 is not forwarded
    op(MEM_NOP, 32'h0000_0055, 32'h0, 5'd0, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd0, 32'h0000_0055);
    #1;
    check("fwd_valid_x0", fwd_valid_o, 0);
    @(negedge clk_i);

    // CSR fields pass through; trap suppresses csr_we
    op(MEM_NOP, 32'h0000_0077, 32'h0, 5'd4, 1'b1, NO_TRAP);
    is_csr_i = 1'b1; csr_we_i = 1'b1; csr_waddr_i = 12'h305; csr_wdata_i = 32'hCAFE_F00D;
    push(1'b1, NO_TRAP, 5'd4, 32'h0000_0077);
    after_edge();
    check("csr_is_csr", is_csr_o, 1);
    check("csr_we", csr_we_o, 1);
    check("csr_waddr", csr_waddr_o, 12'h305);
    check("csr_wdata", csr_wdata_o, 32'hCAFE_F00D);
    @(negedge clk_i);
    op(LW, 32'h0000_2002, 32'h0, 5'd4, 1'b1, NO_TRAP);
    is_csr_i = 1'b1; csr_we_i = 1'b1;
    push(1'b0, LOAD_ADDR_MISALIGNED, 5'd4, 32'h0000_0000);
    after_edge();
    check("csr_we_trap", csr_we_o, 0);
    @(negedge clk_i);

    // Three-cycle stall on a load; LSU word disappears after the first
    op(LW, 32'h0000_2000, 32'hDEAD_BEEF, 5'd7, 1'b1, NO_TRAP);
    stall_i = 1'b1;
    after_edge();
    check("hold_valid_set", dut.hold_valid_q, 1);
    @(negedge clk_i);
    lsu_rdata_i = 32'h0;
    #1;
    check("fwd_data_held", fwd_data_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    @(negedge clk_i);
    stall_i = 1'b0;
    push(1'b1, NO_TRAP, 5'd7, 32'hDEAD_BEEF);
    after_edge();
    check("hold_valid_release", dut.hold_valid_q, 0);
    @(negedge clk_i);

    // Stall and flush together: flush wins and drops the held word
    op(LW, 32'h0000_2000, 32'h0000_0012, 5'd8, 1'b1, NO_TRAP);
    stall_i = 1'b1;
    @(negedge clk_i);
    op(MEM_NOP, 32'h0000_0099, 32'h0, 5'd9, 1'b1, NO_TRAP);
    stall_i = 1'b1; flush_i = 1'b1;
    after_edge();
    check("flush_hold_valid", dut.hold_valid_q, 0);
    check("flush_instr_valid", instr_valid_o, 0);
    check("flush_write_rd", write_rd_o, 0);
    @(negedge clk_i);
    idle();
    @(negedge clk_i);

    // Reset during a stall discards the held word
    op(LW, 32'h0000_2004, 32'hAAAA_5555, 5'd10, 1'b1, NO_TRAP);
    stall_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b0;
    after_edge();
    check("rst_stall_hold", dut.hold_valid_q, 0);
    check("rst_stall_valid", instr_valid_o, 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    op(LW, 32'h0000_2004, 32'h1111_2222, 5'd10, 1'b1, NO_TRAP);
    push(1'b1, NO_TRAP, 5'd10, 32'h1111_2222);
    @(negedge clk_i);
    idle();
    repeat (3) @(negedge clk_i);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
